fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I pipeline. It holds the PC and drives the instruction-memory request/ready handshake. It buffers one returned word when decode is stalled and presents InstrD/PCD/PCPlus4D to the decode stage, where InstrD[31:7] feeds the immediate extender. It also applies branch/jump redirects and hazard-unit stall/flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, address/data width; only 32 is supported.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
StallF  in  1  hazard unit: hold PC, issue no new request.
StallD  in  1  hazard unit: hold IF/ID outputs.
FlushD  in  1  hazard unit: squash IF/ID contents.
PCSrcE  in  1  redirect taken (from execute).
PCTargetE  in  32  redirect target.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch address (= PCF).
imem_ready  in  1  memory returns imem_rdata this cycle for imem_addr.
imem_rdata  in  32  instruction word.
InstrD  out  32  decoded-stage instruction.
PCD  out  32  PC of InstrD.
PCPlus4D  out  32  PCD+4.
ValidD  out  1  InstrD is a real instruction (0 = bubble).
FetchBusy  out  1  imem_req & !imem_ready; goes to the hazard unit.

Behaviour:
- State machine, two states:
  - FETCH: imem_req = !StallF. Accept = imem_req & imem_ready; the handshake is same-cycle, with no outstanding transactions.
  - HOLD: one instruction is parked in the skid buffer (instr, pc); imem_req = 0.
- Transitions:
  - FETCH->HOLD on accept & StallD & !FlushD & !PCSrcE.
  - HOLD->FETCH when !StallD (buffer moves into IF/ID), or on FlushD or PCSrcE (buffer discarded).
- PCF update, priority reset > PCSrcE > accept > hold:
  - Redirect: PCF <= {PCTargetE[31:2],2'b00}.
  - Accept: PCF <= PCF+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - Otherwise PCF is held.
- IF/ID register update, priority reset > FlushD or PCSrcE > StallD > load:
  - Flush: InstrD=NOP, ValidD=0; PCD and PCPlus4D hold.
  - StallD: all outputs hold.
  - Load from the skid buffer (in HOLD), else from imem on accept (ValidD=1, PCD=PCF, PCPlus4D=PCF+4), else a bubble (NOP, ValidD=0).
- Any instruction accepted in a cycle with PCSrcE=1 is discarded, regardless of FlushD.
- Latency: an instruction accepted in cycle N appears on InstrD in cycle N+1 when not stalled.
- Reset, synchronous: PCF=RESET_PC, state=FETCH, InstrD=32'h0000_0013 (NOP), ValidD=0, PCD=0, PCPlus4D=0, skid buffer cleared. imem_req is high in the first cycle after reset deassertion.
- Reset mid-HOLD: the buffered word is lost and fetch restarts at RESET_PC.
- StallF & StallD both high: no request issued, PC and outputs held.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs FetchCount[31:0] (count of accepts) and BubbleCount[31:0] (cycles ValidD loaded as 0). Both clear on reset and wrap at 2^32.
- Undefined: these ports and their counters are absent.

Decomposition:
- Package riscv_pkg: NOP_INSTR = 32'h0000_0013, fetch-state enum {FETCH, HOLD}, default RESET_PC.
- Sub-module fetch_skid_buf: one-entry instr+pc buffer with load/drain/clear controls.

Test Plan:
- Reset release, imem_ready=1 constantly: imem_addr sequence 0,4,8; InstrD follows one cycle later; ValidD=1 from cycle 2.
- imem_ready=0 for 3 cycles at PC=8: FetchBusy=1 for 3 cycles, ValidD=0 bubbles, PC stays 8; then InstrD = word@8.
- Accept at PC=0x10 while StallD=1 for 2 cycles: imem_req drops (HOLD), InstrD unchanged. After the stall, InstrD = word@0x10, PCD=0x10, next fetch at 0x14.
- PCSrcE=1, PCTargetE=0x203 while accepting at 0x20: next imem_addr=0x200, the word@0x20 never reaches InstrD, InstrD=NOP, ValidD=0.
- FlushD during HOLD: buffer dropped, InstrD=NOP/ValidD=0, fetch resumes at the held PC+4.
- PCF=0xFFFF_FFFC accepted: next imem_addr=0x0000_0000, PCPlus4D=0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared constants and types for the RV32I fetch stage:
//             canonical NOP encoding, default reset PC, fetch FSM state
//             encoding and a PC-increment helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   // ADDI x0, x0, 0 -- the canonical RV32I NOP used for squashed slots
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_e;

   // Sequential PC; wraps naturally at 2^32
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_skid_buf
//  Purpose  : One-entry buffer parking a fetched instruction and its PC
//             while the decode stage is stalled.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             load              - capture load_instr/load_pc, mark valid
//             drain             - entry consumed, mark empty
//             clear             - discard entry (flush/redirect)
//             load_instr/pc     - word and PC to capture
//             valid/instr/pc    - buffered entry
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_skid_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        drain,
   input  logic        clear,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc,
   output logic        valid,
   output logic [31:0] instr,
   output logic [31:0] pc
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : RV32I instruction-fetch stage with IF/ID pipeline register.
//             Holds PCF, runs a same-cycle req/ready handshake with the
//             instruction memory, parks one returned word in a skid buffer
//             while decode is stalled, and applies redirects and
//             hazard-unit stall/flush.
//  Params   : RESET_PC - PC loaded on reset
//             XLEN     - address/data width (only 32 supported)
//  Ports    : clk, reset                 - clock, sync active-high reset
//             StallF, StallD, FlushD     - hazard-unit controls
//             PCSrcE, PCTargetE          - redirect from execute
//             imem_req/addr/ready/rdata  - instruction memory handshake
//             InstrD, PCD, PCPlus4D,
//             ValidD                     - IF/ID register outputs
//             FetchBusy                  - request pending without data
//             FetchCount, BubbleCount    - perf counters (optional)
//  Options  : define FETCH_PERF_CNT_EN to add FetchCount/BubbleCount.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            StallF,
   input  logic            StallD,
   input  logic            FlushD,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]     FetchCount,
   output logic [31:0]     BubbleCount,
`endif
   output logic            FetchBusy
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

   fetch_state_e    state;
   fetch_state_e    state_next;
   logic [XLEN-1:0] pcf;
   logic [XLEN-1:0] redirect_pc;
   logic            accept;
   logic            squash;
   logic            skid_load;
   logic            skid_drain;
   logic            skid_valid;
   logic [31:0]     skid_instr;
   logic [31:0]     skid_pc;
   logic            from_skid;
   logic            bubble_load;

   // A redirect or decode flush squashes both IF/ID and the skid buffer
   assign squash      = FlushD | PCSrcE;
   // Masking (not slicing) keeps every target bit in use
   assign redirect_pc = PCTargetE & ALIGN_MASK;
   assign imem_addr   = pcf;
   assign accept      = imem_req & imem_ready;
   assign FetchBusy   = imem_req & ~imem_ready;
   assign from_skid   = (state == HOLD) & skid_valid;

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next-state and request/skid control
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      case (state)
         FETCH: begin
            imem_req = ~StallF;
            // A word arriving while decode is stalled must be parked;
            // a squash in the same cycle discards it instead.
            if (~StallF && imem_ready && StallD && !squash) begin
               state_next = HOLD;
               skid_load  = 1'b1;
            end
         end
         HOLD: begin
            if (squash) begin
               state_next = FETCH;
            end else if (!StallD) begin
               state_next = FETCH;
               skid_drain = 1'b1;
            end
         end
         default: state_next = FETCH;
      endcase
   end

   // ---------------------------------------------------------------------
   // Program counter: redirect > accept > hold
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         pcf <= RESET_PC;
      end else if (PCSrcE) begin
         pcf <= redirect_pc;
      end else if (accept) begin
         pcf <= pc_next(pcf);
      end
   end

   fetch_skid_buf u_skid (
      .clk        (clk),
      .reset      (reset),
      .load       (skid_load),
      .drain      (skid_drain),
      .clear      (squash),
      .load_instr (imem_rdata),
      .load_pc    (pcf),
      .valid      (skid_valid),
      .instr      (skid_instr),
      .pc         (skid_pc)
   );

   // ---------------------------------------------------------------------
   // IF/ID register: squash > stall > load (skid, memory, or bubble)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         InstrD   <= NOP_INSTR;
         ValidD   <= 1'b0;
         PCD      <= '0;
         PCPlus4D <= '0;
      end else if (squash) begin
         // PCD/PCPlus4D deliberately keep their last values
         InstrD <= NOP_INSTR;
         ValidD <= 1'b0;
      end else if (!StallD) begin
         if (from_skid) begin
            InstrD   <= skid_instr;
            ValidD   <= 1'b1;
            PCD      <= skid_pc;
            PCPlus4D <= pc_next(skid_pc);
         end else if (accept) begin
            InstrD   <= imem_rdata;
            ValidD   <= 1'b1;
            PCD      <= pcf;
            PCPlus4D <= pc_next(pcf);
         end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
         end
      end
   end

   // Cycles in which IF/ID is written with ValidD = 0
   assign bubble_load = squash | (~StallD & ~from_skid & ~accept);

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         FetchCount  <= '0;
         BubbleCount <= '0;
      end else begin
         if (accept) begin
            FetchCount <= FetchCount + 32'd1;
         end
         if (bubble_load) begin
            BubbleCount <= BubbleCount + 32'd1;
         end
      end
   end
`else
   // Without the counters the bubble indication has no consumer
   logic unused_bubble;
   assign unused_bubble = bubble_load;
`endif

endmodule
`default_nettype wire
